// File: rtl/uart_sim_pkg.sv
//------------------------------------------------------------------------------
// Module : uart_sim_pkg
// Brief  : Shared types and constants for the simulation-side UART responder.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_sim_pkg;
  typedef logic [7:0] uart_char_t;

  localparam uart_char_t UART_EMPTY_CHAR = 8'hFF;
  localparam int         UART_FIFO_DEPTH = 16;
endpackage

`default_nettype wire

// File: rtl/uart_sim_fifo.sv
//------------------------------------------------------------------------------
// Module : uart_sim_fifo
// Brief  : Synchronous character FIFO with count, flush and registered head.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_sim_fifo
  import uart_sim_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  uart_char_t    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          full,
  output uart_char_t    head
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  uart_char_t    mem_q [DEPTH];
  uart_char_t    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Space and data availability come from registered count only, so a
  // same-cycle pop never makes room for a push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != FULL_COUNT);
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign full  = (count_q == FULL_COUNT);
  assign head  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/uart_in_responder.sv
//------------------------------------------------------------------------------
// Module : uart_in_responder
// Brief  : Answers SimTop UART reads from a host-fed FIFO, else EMPTY_CHAR.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_in_responder
  import uart_sim_pkg::*;
#(
  parameter int         DEPTH      = UART_FIFO_DEPTH,
  parameter uart_char_t EMPTY_CHAR = UART_EMPTY_CHAR,
  parameter int         CNT_W      = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_uart_in_valid,
  output logic [7:0]             io_uart_in_ch,
  input  logic                   host_push_valid,
  output logic                   host_push_ready,
  input  logic [7:0]             host_push_data,
  input  logic                   host_flush,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       empty_reads
);

  logic [$clog2(DEPTH):0] count;
  logic                   full;
  uart_char_t             head;
  logic                   empty_read;
  logic [CNT_W-1:0]       empty_reads_q, empty_reads_d;

  uart_sim_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (host_push_valid),
    .push_data (host_push_data),
    .pop       (io_uart_in_valid),
    .flush     (host_flush),
    .count     (count),
    .full      (full),
    .head      (head)
  );

  // Flush does not mask the statistic: an empty read is still an empty read.
  always_comb begin
    empty_read    = io_uart_in_valid && (count == '0);
    empty_reads_d = empty_reads_q;
    if (empty_read && !(&empty_reads_q)) begin
      empty_reads_d = empty_reads_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      empty_reads_q <= '0;
    end else begin
      empty_reads_q <= empty_reads_d;
    end
  end

  assign io_uart_in_ch   = (count != '0) ? head : EMPTY_CHAR;
  assign host_push_ready = !full;
  assign fifo_count      = count;
  assign empty_reads     = empty_reads_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_in_responder.sv
//------------------------------------------------------------------------------
// Module : tb_uart_in_responder
// Brief  : Scoreboard bench for uart_in_responder (plus a CNT_W=4 instance).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_in_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_uart_in_valid = 1'b0;
  logic        host_push_valid = 1'b0;
  logic        host_flush = 1'b0;
  logic [7:0]  host_push_data = 8'h00;
  logic [7:0]  io_uart_in_ch;
  logic        host_push_ready;
  logic [4:0]  fifo_count;
  logic [31:0] empty_reads;
  logic [7:0]  sat_ch;
  logic        sat_ready;
  logic [4:0]  sat_count;
  logic [3:0]  sat_empty_reads;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  sb[$];
  int          exp_empty = 0;
  logic [7:0]  exp_ch;

  always #5 clock = ~clock;

  uart_in_responder dut (
    .clock            (clock),
    .reset            (reset),
    .io_uart_in_valid (io_uart_in_valid),
    .io_uart_in_ch    (io_uart_in_ch),
    .host_push_valid  (host_push_valid),
    .host_push_ready  (host_push_ready),
    .host_push_data   (host_push_data),
    .host_flush       (host_flush),
    .fifo_count       (fifo_count),
    .empty_reads      (empty_reads)
  );

  uart_in_responder #(.CNT_W(4)) dut_sat (
    .clock            (clock),
    .reset            (reset),
    .io_uart_in_valid (io_uart_in_valid),
    .io_uart_in_ch    (sat_ch),
    .host_push_valid  (host_push_valid),
    .host_push_ready  (sat_ready),
    .host_push_data   (host_push_data),
    .host_flush       (host_flush),
    .fifo_count       (sat_count),
    .empty_reads      (sat_empty_reads)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_cycle(input logic [7:0] c);
    host_push_valid = 1'b1;
    host_push_data  = c;
    @(posedge clock);
    if (sb.size() < 16) sb.push_back(c);
    #1;
    host_push_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    host_push_valid = 1'b1;
    host_push_data = 8'h99;
    io_uart_in_valid = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    host_push_valid = 1'b0;
    io_uart_in_valid = 1'b0;
    sb.delete();
    exp_empty = 0;
    @(negedge clock);
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (empty_reads !== 32'd0) begin failures++; $display("FAIL reset_empty_reads got=%0d exp=0", empty_reads); end
    checks++; if (io_uart_in_ch !== 8'hFF) begin failures++; $display("FAIL reset_ch got=%h exp=ff", io_uart_in_ch); end
    checks++; if (host_push_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", host_push_ready); end
    step();
  endtask

  task automatic test_in_order();
    push_cycle(8'h41);
    push_cycle(8'h42);
    for (int i = 0; i < 3; i++) begin
      io_uart_in_valid = 1'b1;
      exp_ch = (sb.size() != 0) ? sb[0] : 8'hFF;
      @(negedge clock);
      checks++; if (io_uart_in_ch !== exp_ch) begin failures++; $display("FAIL in_order_read%0d got=%h exp=%h", i, io_uart_in_ch, exp_ch); end
      step();
      if (sb.size() != 0) void'(sb.pop_front()); else exp_empty++;
    end
    io_uart_in_valid = 1'b0;
    @(negedge clock);
    checks++; if (empty_reads !== 32'(exp_empty)) begin failures++; $display("FAIL in_order_empty_reads got=%0d exp=%0d", empty_reads, exp_empty); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL in_order_count got=%0d exp=0", fifo_count); end
    step();
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < 16; i++) push_cycle(8'(i));
    @(negedge clock);
    checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", fifo_count); end
    checks++; if (host_push_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", host_push_ready); end
    step();
    host_push_valid = 1'b1;
    host_push_data  = 8'h10;
    step();
    @(negedge clock);
    checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL full_17th_rejected got=%0d exp=16", fifo_count); end
    step();
    io_uart_in_valid = 1'b1;
    exp_ch = sb[0];
    @(negedge clock);
    checks++; if (io_uart_in_ch !== exp_ch) begin failures++; $display("FAIL full_first_read got=%h exp=%h", io_uart_in_ch, exp_ch); end
    step();
    void'(sb.pop_front());
    io_uart_in_valid = 1'b0;
    @(negedge clock);
    checks++; if (fifo_count !== 5'd15) begin failures++; $display("FAIL full_after_read_count got=%0d exp=15", fifo_count); end
    checks++; if (host_push_ready !== 1'b1) begin failures++; $display("FAIL full_after_read_ready got=%b exp=1", host_push_ready); end
    step();
    sb.push_back(8'h10);
    host_push_valid = 1'b0;
    @(negedge clock);
    checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL full_refill_count got=%0d exp=16", fifo_count); end
    step();
    io_uart_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_ch = (sb.size() != 0) ? sb[0] : 8'hFF;
      @(negedge clock);
      checks++; if (io_uart_in_ch !== exp_ch) begin failures++; $display("FAIL wrap_read%0d got=%h exp=%h", i, io_uart_in_ch, exp_ch); end
      step();
      if (sb.size() != 0) void'(sb.pop_front()); else exp_empty++;
    end
    io_uart_in_valid = 1'b0;
    @(negedge clock);
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL wrap_drained_count got=%0d exp=0", fifo_count); end
    step();
  endtask

  task automatic test_empty_collision();
    host_push_valid  = 1'b1;
    host_push_data   = 8'h55;
    io_uart_in_valid = 1'b1;
    @(negedge clock);
    checks++; if (io_uart_in_ch !== 8'hFF) begin failures++; $display("FAIL collide_ch got=%h exp=ff", io_uart_in_ch); end
    step();
    exp_empty++;
    sb.push_back(8'h55);
    host_push_valid  = 1'b0;
    io_uart_in_valid = 1'b0;
    @(negedge clock);
    checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL collide_count got=%0d exp=1", fifo_count); end
    checks++; if (empty_reads !== 32'(exp_empty)) begin failures++; $display("FAIL collide_empty_reads got=%0d exp=%0d", empty_reads, exp_empty); end
    step();
    io_uart_in_valid = 1'b1;
    exp_ch = sb[0];
    @(negedge clock);
    checks++; if (io_uart_in_ch !== exp_ch) begin failures++; $display("FAIL collide_next_read got=%h exp=%h", io_uart_in_ch, exp_ch); end
    step();
    void'(sb.pop_front());
    io_uart_in_valid = 1'b0;
  endtask

  task automatic test_flush();
    push_cycle(8'h61);
    push_cycle(8'h62);
    push_cycle(8'h63);
    host_flush       = 1'b1;
    host_push_valid  = 1'b1;
    host_push_data   = 8'h64;
    io_uart_in_valid = 1'b1;
    exp_ch = sb[0];
    @(negedge clock);
    checks++; if (io_uart_in_ch !== exp_ch) begin failures++; $display("FAIL flush_head got=%h exp=%h", io_uart_in_ch, exp_ch); end
    step();
    sb.delete();
    host_flush       = 1'b0;
    host_push_valid  = 1'b0;
    io_uart_in_valid = 1'b0;
    @(negedge clock);
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", fifo_count); end
    checks++; if (io_uart_in_ch !== 8'hFF) begin failures++; $display("FAIL flush_ch got=%h exp=ff", io_uart_in_ch); end
    checks++; if (empty_reads !== 32'(exp_empty)) begin failures++; $display("FAIL flush_empty_reads got=%0d exp=%0d", empty_reads, exp_empty); end
    step();
    // Flush together with an empty read still counts the read.
    host_flush       = 1'b1;
    io_uart_in_valid = 1'b1;
    step();
    exp_empty++;
    host_flush       = 1'b0;
    io_uart_in_valid = 1'b0;
    @(negedge clock);
    checks++; if (empty_reads !== 32'(exp_empty)) begin failures++; $display("FAIL flush_empty_read got=%0d exp=%0d", empty_reads, exp_empty); end
    step();
  endtask

  task automatic test_reset_and_saturation();
    for (int i = 0; i < 5; i++) push_cycle(8'hA0 + 8'(i));
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    exp_empty = 0;
    @(negedge clock);
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", fifo_count); end
    checks++; if (io_uart_in_ch !== 8'hFF) begin failures++; $display("FAIL midreset_ch got=%h exp=ff", io_uart_in_ch); end
    step();
    io_uart_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_empty++;
      if (i == 14) begin
        @(negedge clock);
        checks++; if (sat_empty_reads !== 4'hF) begin failures++; $display("FAIL sat_reach got=%h exp=f", sat_empty_reads); end
      end
    end
    io_uart_in_valid = 1'b0;
    @(negedge clock);
    checks++; if (sat_empty_reads !== 4'hF) begin failures++; $display("FAIL sat_hold got=%h exp=f", sat_empty_reads); end
    checks++; if (empty_reads !== 32'(exp_empty)) begin failures++; $display("FAIL wide_empty_reads got=%0d exp=%0d", empty_reads, exp_empty); end
    step();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_boundary();
    test_empty_collision();
    test_flush();
    test_reset_and_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
